// File: rtl/rsa_modexp.sv
// Iterative modular exponentiation: result = msg^exp mod modulus.
// Right-to-left square-and-multiply over a bit-serial interleaved modular multiplier.
module rsa_modexp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, FINISH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] msg_q, msg_d, exp_q, exp_d, n_q, n_d;
  logic [WIDTH-1:0] acc_q, acc_d, base_q, base_d, p_q, p_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    j_q, j_d, i_q, i_d, i_nx;
  logic             busy_q, busy_d, done_q, done_d;

  // One step of mm(A,B): shift-add then up to two conditional subtracts of n.
  logic [WIDTH-1:0] op_a, op_b, p_nx;
  logic [WIDTH+1:0] t0, t1, t2, n_ext;

  always_comb begin
    op_a = base_q;
    op_b = base_q;
    case (state_q)
      REDUCE: begin op_a = msg_q;  op_b = WIDTH'(1); end
      MUL:    begin op_a = base_q; op_b = acc_q;     end
      default: ;
    endcase
    n_ext = {2'b00, n_q};
    t0    = {1'b0, p_q, 1'b0} + (op_a[j_q] ? {2'b00, op_b} : '0);
    t1    = (t0 >= n_ext) ? t0 - n_ext : t0;
    t2    = (t1 >= n_ext) ? t1 - n_ext : t1;
    p_nx  = t2[WIDTH-1:0];
    i_nx  = i_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    exp_d    = exp_q;
    n_d      = n_q;
    acc_d    = acc_q;
    base_d   = base_q;
    p_d      = p_q;
    j_d      = j_q;
    i_d      = i_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          msg_d  = msg;
          exp_d  = exp;
          n_d    = modulus;
          i_d    = '0;
          p_d    = '0;
          j_d    = IW'(WIDTH-1);
          base_d = '0;
          // acc doubles as the pending result; degenerate moduli yield 0
          if (modulus < WIDTH'(2)) begin
            acc_d   = '0;
            state_d = FINISH;
          end else begin
            acc_d   = WIDTH'(1);
            state_d = REDUCE;
          end
        end
      end
      REDUCE, MUL, SQR: begin
        p_d = p_nx;
        j_d = j_q - 1'b1;
        if (j_q == '0) begin
          p_d = '0;
          j_d = IW'(WIDTH-1);
          case (state_q)
            REDUCE: begin
              base_d  = p_nx;
              state_d = exp_q[0] ? MUL : SQR;
            end
            MUL: begin
              acc_d   = p_nx;
              state_d = SQR;
            end
            default: begin
              base_d = p_nx;
              if (i_q == IW'(WIDTH-1)) begin
                state_d = FINISH;
              end else begin
                i_d     = i_nx;
                state_d = exp_q[i_nx] ? MUL : SQR;
              end
            end
          endcase
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
    if (state_d == FINISH) result_d = acc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      msg_q    <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      p_q      <= '0;
      j_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      p_q      <= p_d;
      j_q      <= j_d;
      i_q      <= i_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed bench for rsa_modexp: hand-computed results and latencies.
module tb_rsa_modexp;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] msg, exp, modulus, result;
  logic        busy, done;
  int          total = 0, bad = 0;

  rsa_modexp #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .msg(msg), .exp(exp),
    .modulus(modulus), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Issue one start, optionally poke a second start at cycle `poke`, check result/latency.
  task automatic run(input string tag, input logic [31:0] m, input logic [31:0] e,
                     input logic [31:0] n, input logic [31:0] res, input int lat, input int poke);
    int cnt;
    bit busy_ok;
    @(posedge clk); #1;
    msg = m; exp = e; modulus = n; start = 1'b1;
    cnt = 0; busy_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cnt++;
      if (!busy) busy_ok = 1'b0;
      if (poke > 0 && cnt == poke) begin
        msg = 32'd123; exp = 32'd5; modulus = 32'd1000; start = 1'b1;
      end
    end while (!done && cnt < 5000);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".lat"}, 64'(cnt), 64'(lat));
    chk({tag, ".res"}, 64'(result), 64'(res));
    chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
    @(posedge clk); #1;
    chk({tag, ".after"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    bit extra;
    reset = 1'b1; start = 1'b0; msg = '0; exp = '0; modulus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    reset = 1'b0;

    run("rsa65",   32'd65, 32'd17, 32'd3233, 32'd2790, 1121, 0);
    run("m4e13",   32'd4,  32'd13, 32'd497,  32'd445,  1153, 0);
    run("exp0",    32'd7,  32'd0,  32'd13,   32'd1,    1057, 0);
    run("bigmsg",  32'd20, 32'd3,  32'd7,    32'd6,    1121, 0);
    run("topcar",  32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd1, 1089, 0);
    run("mod0",    32'd9,  32'd5,  32'd0,    32'd0,    1,    0);
    run("mod1",    32'd9,  32'd5,  32'd1,    32'd0,    1,    0);
    run("zero^5",  32'd0,  32'd5,  32'd13,   32'd0,    1121, 0);
    run("zero^0",  32'd0,  32'd0,  32'd13,   32'd1,    1057, 0);
    run("2^10",    32'd2,  32'd10, 32'd1000, 32'd24,   1121, 0);

    // Second start mid-run must be dropped: same result, no second done.
    run("poke",    32'd65, 32'd17, 32'd3233, 32'd2790, 1121, 200);
    extra = 1'b0;
    repeat (1200) begin
      @(posedge clk); #1;
      if (done || busy) extra = 1'b1;
    end
    chk("poke.nodone", 64'(extra), 64'd0);

    // Reset while in SQR (cycles 65..96 of this operand set).
    @(posedge clk); #1;
    msg = 32'd65; exp = 32'd17; modulus = 32'd3233; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (79) @(posedge clk);
    #1;
    chk("mid.busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst.busy", 64'(busy), 64'd0);
    chk("mrst.done", 64'(done), 64'd0);
    chk("mrst.result", 64'(result), 64'd0);
    extra = 1'b0;
    repeat (1200) begin
      @(posedge clk); #1;
      if (done) extra = 1'b1;
    end
    chk("mrst.nodone", 64'(extra), 64'd0);
    run("fresh",   32'd65, 32'd17, 32'd3233, 32'd2790, 1121, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
